// File: rtl/mcpu_core_dcache_if.sv
// mcpu_core_dcache_if
// Groups the core-side (mem2dc_*) request/done bus and the memory-side
// (dc2mem_*) req/ack bus of the data cache.
//   slave  : the cache view. It takes core requests and memory responses,
//            and drives done/data_in and the memory request.
//   master : the environment view. It is the core plus the memory arbiter.
interface mcpu_core_dcache_if;
  logic [29:0] mem2dc_paddr;
  logic [3:0]  mem2dc_write;
  logic        mem2dc_valid;
  logic [31:0] mem2dc_data_out;
  logic        mem2dc_done;
  logic [31:0] mem2dc_data_in;

  logic        dc2mem_req;
  logic [29:0] dc2mem_addr;
  logic [3:0]  dc2mem_we;
  logic [31:0] dc2mem_wdata;
  logic        dc2mem_ack;
  logic [31:0] dc2mem_rdata;

  modport slave (
    input  mem2dc_paddr, mem2dc_write, mem2dc_valid, mem2dc_data_out,
    input  dc2mem_ack, dc2mem_rdata,
    output mem2dc_done, mem2dc_data_in,
    output dc2mem_req, dc2mem_addr, dc2mem_we, dc2mem_wdata
  );

  modport master (
    output mem2dc_paddr, mem2dc_write, mem2dc_valid, mem2dc_data_out,
    output dc2mem_ack, dc2mem_rdata,
    input  mem2dc_done, mem2dc_data_in,
    input  dc2mem_req, dc2mem_addr, dc2mem_we, dc2mem_wdata
  );
endinterface

// File: rtl/mcpu_core_dcache.sv
// mcpu_core_dcache
// Direct-mapped, write-through, read-allocate data cache with one-word lines.
// It holds one outstanding request at a time.
// Ports:
//   clkrst_core_clk : core clock
//   clkrst_core_rst : asynchronous, active-high reset
//   bus (slave)     : mem2dc_* core request/done bus and dc2mem_* memory
//                     req/ack bus
//
// state  | meaning
// IDLE   | no request pending; done=1 and data_in=0
// LOOKUP | tag compare on the registered request; a read hit completes here
// MEM    | memory request held until ack (read miss, or any write)
// RESP   | done=1 and the response register is shown on data_in
module mcpu_core_dcache #(
  parameter int SET_BITS = 6
) (
  input logic             clkrst_core_clk,
  input logic             clkrst_core_rst,
  mcpu_core_dcache_if.slave bus
);

  localparam int NSETS = 1 << SET_BITS;
  localparam int TAG_W = 30 - SET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM,
    ST_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [29:0]       paddr_q, paddr_d;
  logic [3:0]        we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       resp_q, resp_d;
  logic [NSETS-1:0]  valid_q, valid_d;

  // The tag and data arrays have no reset; the valid bits alone gate them.
  logic [TAG_W-1:0]  tag_q  [NSETS];
  logic [31:0]       data_q [NSETS];
  logic              data_wr_en;
  logic [31:0]       data_d;
  logic              tag_wr_en;

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    reg_tag;
  logic                hit;
  logic                is_read;
  logic                done;
  logic [31:0]         data_in;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  assign idx     = paddr_q[SET_BITS-1:0];
  assign reg_tag = paddr_q[29:SET_BITS];
  assign hit     = valid_q[idx] && (tag_q[idx] == reg_tag);
  assign is_read = (we_q == 4'b0000);

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    valid_d    = valid_q;
    done       = 1'b0;
    data_in    = '0;
    data_wr_en = 1'b0;
    data_d     = data_q[idx];
    tag_wr_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        done = 1'b1;
      end
      ST_LOOKUP: begin
        if (is_read && hit) begin
          done    = 1'b1;
          data_in = data_q[idx];
        end else begin
          state_d = ST_MEM;
          // A write hit updates the line now; memory is written in MEM.
          if (!is_read && hit) begin
            data_wr_en = 1'b1;
            data_d     = byte_merge(data_q[idx], wdata_q, we_q);
          end
        end
      end
      ST_MEM: begin
        if (bus.dc2mem_ack) begin
          state_d = ST_RESP;
          if (is_read) begin
            data_wr_en   = 1'b1;
            data_d       = bus.dc2mem_rdata;
            tag_wr_en    = 1'b1;
            valid_d[idx] = 1'b1;
            resp_d       = bus.dc2mem_rdata;
          end else begin
            resp_d = '0;
          end
        end
      end
      ST_RESP: begin
        done    = 1'b1;
        data_in = resp_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new request can be accepted in any cycle that shows done.
    if (done) begin
      if (bus.mem2dc_valid) begin
        state_d = ST_LOOKUP;
        paddr_d = bus.mem2dc_paddr;
        we_d    = bus.mem2dc_write;
        wdata_d = bus.mem2dc_data_out;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      state_q <= ST_IDLE;
      paddr_q <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (data_wr_en) data_q[idx] <= data_d;
    if (tag_wr_en)  tag_q[idx]  <= reg_tag;
  end

  // The memory-side outputs are gated by MEM. Reset therefore drops the
  // request at once, and the bus reads as zero outside a transaction.
  assign bus.mem2dc_done    = done;
  assign bus.mem2dc_data_in = data_in;
  assign bus.dc2mem_req     = (state_q == ST_MEM);
  assign bus.dc2mem_addr    = (state_q == ST_MEM) ? paddr_q : '0;
  assign bus.dc2mem_we      = (state_q == ST_MEM) ? we_q    : '0;
  assign bus.dc2mem_wdata   = (state_q == ST_MEM) ? wdata_q : '0;

endmodule

// File: tb/tb_mcpu_core_dcache.sv
module tb_mcpu_core_dcache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  mcpu_core_dcache_if bus();

  mcpu_core_dcache #(.SET_BITS(6)) dut (
    .clkrst_core_clk(clk),
    .clkrst_core_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: a memory image plus a map of which word each set holds.
  bit          mv [64];
  logic [23:0] mt [64];
  logic [31:0] md [64];
  logic [31:0] mem_m [logic [29:0]];

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {2'b00, a} * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_quiet_bus(input string name);
    chk({name, "_req"},   {31'd0, bus.dc2mem_req}, 32'd0);
    chk({name, "_addr"},  {2'b00, bus.dc2mem_addr}, 32'd0);
    chk({name, "_we"},    {28'd0, bus.dc2mem_we}, 32'd0);
    chk({name, "_wdata"}, bus.dc2mem_wdata, 32'd0);
  endtask

  // Called at a negedge with done high. It returns at a negedge with done
  // high again and leaves valid asserted, so the caller must drive the next
  // stimulus before time advances.
  task automatic do_req(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d,
                        input int dly, output logic lk_done, output logic [31:0] rsp);
    logic [5:0]  ix;
    logic [23:0] tg;
    bit          hit;
    logic [31:0] exp_rd;
    ix = a[5:0];
    tg = a[29:6];
    bus.mem2dc_valid    = 1'b1;
    bus.mem2dc_paddr    = a;
    bus.mem2dc_write    = m;
    bus.mem2dc_data_out = d;
    @(posedge clk); @(negedge clk);
    hit = mv[ix] && (mt[ix] == tg);
    lk_done = bus.mem2dc_done;
    rsp = bus.mem2dc_data_in;
    if (m == 4'b0000 && hit) begin
      chk("lookup_done", {31'd0, bus.mem2dc_done}, 32'd1);
      chk("lookup_data", bus.mem2dc_data_in, md[ix]);
      chk("lookup_req",  {31'd0, bus.dc2mem_req}, 32'd0);
    end else begin
      chk("lookup_done", {31'd0, bus.mem2dc_done}, 32'd0);
      chk("lookup_req",  {31'd0, bus.dc2mem_req}, 32'd0);
      exp_rd = mem_rd(a);
      if (m != 4'b0000) begin
        mem_m[a] = merge(exp_rd, d, m);
        if (hit) md[ix] = merge(md[ix], d, m);
      end
      for (int c = 0; c <= dly; c++) begin
        @(posedge clk); @(negedge clk);
        chk("mem_req",   {31'd0, bus.dc2mem_req}, 32'd1);
        chk("mem_addr",  {2'b00, bus.dc2mem_addr}, {2'b00, a});
        chk("mem_we",    {28'd0, bus.dc2mem_we}, {28'd0, m});
        chk("mem_wdata", bus.dc2mem_wdata, d);
        chk("mem_done",  {31'd0, bus.mem2dc_done}, 32'd0);
        if (c == dly) begin
          bus.dc2mem_ack   = 1'b1;
          bus.dc2mem_rdata = (m == 4'b0000) ? exp_rd : $urandom;
        end
      end
      @(posedge clk); @(negedge clk);
      bus.dc2mem_ack   = 1'b0;
      bus.dc2mem_rdata = $urandom;
      chk("resp_done", {31'd0, bus.mem2dc_done}, 32'd1);
      chk("resp_data", bus.mem2dc_data_in, (m == 4'b0000) ? exp_rd : 32'd0);
      chk("resp_req",  {31'd0, bus.dc2mem_req}, 32'd0);
      if (m == 4'b0000) begin
        mv[ix] = 1'b1;
        mt[ix] = tg;
        md[ix] = exp_rd;
      end
      rsp = bus.mem2dc_data_in;
    end
  endtask

  task automatic idle(input bit stray_ack);
    bus.mem2dc_valid = 1'b0;
    bus.mem2dc_paddr = 30'($urandom);
    bus.dc2mem_ack   = stray_ack;
    bus.dc2mem_rdata = $urandom;
    @(posedge clk); @(negedge clk);
    bus.dc2mem_ack = 1'b0;
    chk("idle_done", {31'd0, bus.mem2dc_done}, 32'd1);
    chk("idle_data", bus.mem2dc_data_in, 32'd0);
    chk_quiet_bus("idle");
  endtask

  logic        lk;
  logic [31:0] rsp;

  initial begin
    bus.mem2dc_valid    = 1'b0;
    bus.mem2dc_paddr    = '0;
    bus.mem2dc_write    = '0;
    bus.mem2dc_data_out = '0;
    bus.dc2mem_ack      = 1'b0;
    bus.dc2mem_rdata    = '0;
    for (int i = 0; i < 64; i++) begin
      mv[i] = 1'b0; mt[i] = '0; md[i] = '0;
    end
    mem_m[30'h40] = 32'hDEAD_BEEF;

    #1;
    chk("rst_done", {31'd0, bus.mem2dc_done}, 32'd1);
    chk("rst_data", bus.mem2dc_data_in, 32'd0);
    chk_quiet_bus("rst");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(1'b0);

    // Read miss followed by a fill.
    do_req(30'h40, 4'b0000, 32'h0, 2, lk, rsp);
    chk("t1_miss", {31'd0, lk}, 32'd0);
    chk("t1_data", rsp, 32'hDEAD_BEEF);
    // Back-to-back hits.
    for (int i = 0; i < 4; i++) begin
      do_req(30'h40, 4'b0000, 32'h0, 0, lk, rsp);
      chk("t2_hit", {31'd0, lk}, 32'd1);
      chk("t2_data", rsp, 32'hDEAD_BEEF);
    end
    // Partial write hit, then a read-back.
    do_req(30'h40, 4'b0010, 32'h0000_AA00, 1, lk, rsp);
    do_req(30'h40, 4'b0000, 32'h0, 0, lk, rsp);
    chk("t3_hit", {31'd0, lk}, 32'd1);
    chk("t3_data", rsp, 32'hDEAD_AAEF);
    // Write miss without allocate, and aliasing at index 0.
    do_req(30'h80, 4'b1111, 32'h1234_5678, 1, lk, rsp);
    do_req(30'h80, 4'b0000, 32'h0, 2, lk, rsp);
    chk("t4_rd80_miss", {31'd0, lk}, 32'd0);
    chk("t4_rd80_data", rsp, 32'h1234_5678);
    do_req(30'h40, 4'b0000, 32'h0, 0, lk, rsp);
    chk("t4_rd40_miss", {31'd0, lk}, 32'd0);
    chk("t4_rd40_data", rsp, 32'hDEAD_AAEF);
    // Ack in the first MEM cycle, then a stray ack while idle.
    do_req(30'h1234, 4'b0000, 32'h0, 0, lk, rsp);
    chk("t5_miss", {31'd0, lk}, 32'd0);
    idle(1'b1);
    idle(1'b0);

    // Reset while a request is held in MEM.
    bus.mem2dc_valid = 1'b1;
    bus.mem2dc_paddr = 30'h3000;
    bus.mem2dc_write = 4'b0000;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("t6_req_before", {31'd0, bus.dc2mem_req}, 32'd1);
    rst = 1'b1;
    bus.mem2dc_valid = 1'b0;
    #1;
    chk("t6_req_drop", {31'd0, bus.dc2mem_req}, 32'd0);
    chk("t6_done", {31'd0, bus.mem2dc_done}, 32'd1);
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0);
    do_req(30'h40, 4'b0000, 32'h0, 1, lk, rsp);
    chk("t6_rd40_miss", {31'd0, lk}, 32'd0);
    chk("t6_rd40_data", rsp, 32'hDEAD_AAEF);

    // Randomized traffic over a few sets and tags, so that hits, aliasing
    // and partial writes all occur.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1'($urandom_range(0, 1)));
      end else begin
        logic [29:0] a;
        logic [3:0]  m;
        a = {24'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
        m = ($urandom_range(0, 9) < 4) ? 4'b0000 : 4'($urandom);
        do_req(a, m, $urandom, $urandom_range(0, 3), lk, rsp);
      end
    end
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
